// File: rtl/single_port_ram_master.sv
// -----------------------------------------------------------------------------
// single_port_ram_master
//
// Purpose:
//   Initiator for a single-port synchronous RAM with a shared bidirectional data
//   bus. It turns valid/ready read and write requests from the matrix-multiply
//   datapath into correctly sequenced RAM cycles. It owns the tri-state
//   turnaround on the data bus and returns exactly one response per request.
//   Only one request is in flight at a time.
//
// Ports:
//   clk        in     rising-edge clock, shared with the RAM
//   rst_n      in     asynchronous active-low reset
//   req_valid  in     request present
//   req_ready  out    request accepted on a clk edge when req_valid & req_ready
//   req_we     in     1 = write, 0 = read
//   req_addr   in     word address
//   req_wdata  in     write data
//   rsp_valid  out    response present, held until rsp_ready
//   rsp_ready  in     response consumed on a clk edge when rsp_valid & rsp_ready
//   rsp_we     out    echo of req_we for this response
//   rsp_err    out    1 = address >= DEPTH, RAM was not accessed
//   rsp_rdata  out    read data (0 for writes and errored requests)
//   ram_addr   out    RAM address
//   ram_data   inout  RAM data bus, driven here only during WRITE
//   ram_cs     out    RAM chip select
//   ram_we     out    RAM write enable
//   ram_oe     out    RAM output enable
// -----------------------------------------------------------------------------
module single_port_ram_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_DATA = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDR_WIDTH:0];

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  in_range;
    logic                  drive_bus;

    assign in_range = ({1'b0, req_addr} < DEPTH_LIMIT);

    // Gating with rst_n keeps the handshake closed for the whole reset pulse,
    // even though the state register already sits in IDLE.
    assign req_ready = rst_n && (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (in_range) begin
                            state <= req_we ? WRITE : RD_ADDR;
                        end else begin
                            // Out-of-range requests never touch the RAM; the
                            // response is ready on the very next edge.
                            state     <= RESP;
                            rsp_we    <= req_we;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                WRITE: begin
                    // The RAM commits the word on the edge that closes this state.
                    state     <= RESP;
                    rsp_we    <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RD_ADDR: begin
                    // The RAM registers mem[addr] on this edge and drives it
                    // once ram_oe rises in RD_DATA.
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    state     <= RESP;
                    rsp_we    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ram_data;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM strobes decode from the registered state only, so nothing on req_*
    // can ripple combinationally onto the RAM pins.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        drive_bus = 1'b0;
        case (state)
            WRITE: begin
                ram_cs    = 1'b1;
                ram_we    = 1'b1;
                drive_bus = 1'b1;
            end
            RD_ADDR: begin
                ram_cs = 1'b1;
            end
            RD_DATA: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            default: begin
                ram_cs = 1'b0;
            end
        endcase
    end

    assign ram_addr = addr_q;

    // The master drives only while we=1/oe=0; the RAM drives only while
    // oe=1/we=0, so the two can never fight over the bus.
    assign ram_data = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_ram_master.sv
module tb_single_port_ram_master;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A: DEPTH 16 (whole address space legal)
    logic          a_req_valid, a_req_we, a_rsp_ready;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_req_ready, a_rsp_valid, a_rsp_we, a_rsp_err;
    logic [DW-1:0] a_rsp_rdata;
    logic [AW-1:0] a_ram_addr;
    wire  [DW-1:0] a_ram_data;
    logic          a_ram_cs, a_ram_we, a_ram_oe;

    // DUT B: DEPTH 12 (addresses 12..15 are errors)
    logic          b_req_valid, b_req_we, b_rsp_ready;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_req_ready, b_rsp_valid, b_rsp_we, b_rsp_err;
    logic [DW-1:0] b_rsp_rdata;
    logic [AW-1:0] b_ram_addr;
    wire  [DW-1:0] b_ram_data;
    logic          b_ram_cs, b_ram_we, b_ram_oe;

    single_port_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_we(a_rsp_we),
        .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
        .ram_addr(a_ram_addr), .ram_data(a_ram_data),
        .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_oe(a_ram_oe)
    );

    single_port_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_we(b_rsp_we),
        .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .ram_addr(b_ram_addr), .ram_data(b_ram_data),
        .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe)
    );

    // Behavioural synchronous single-port RAMs attached to each master.
    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];
    logic [DW-1:0] a_rd_q, b_rd_q;

    always @(posedge clk) begin
        if (a_ram_cs) begin
            if (a_ram_we) a_mem[a_ram_addr] <= a_ram_data;
            else          a_rd_q <= a_mem[a_ram_addr];
        end
        if (b_ram_cs) begin
            if (b_ram_we) b_mem[b_ram_addr] <= b_ram_data;
            else          b_rd_q <= b_mem[b_ram_addr];
        end
    end
    assign a_ram_data = (a_ram_cs && a_ram_oe && !a_ram_we) ? a_rd_q : {DW{1'bz}};
    assign b_ram_data = (b_ram_cs && b_ram_oe && !b_ram_we) ? b_rd_q : {DW{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int b_cs_cnt = 0;
    always @(negedge clk) if (b_ram_cs) b_cs_cnt <= b_cs_cnt + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word arrays updated from the request stream.
    logic [DW-1:0] model_a [16];
    logic [DW-1:0] model_b [16];

    // Issue one request on DUT A (sel=0) or B (sel=1). Called just after a
    // negedge; returns at the negedge where rsp_valid is first seen. Latency
    // counts clock edges from the accept edge (inclusive); 999 means timeout.
    task automatic do_req(input bit sel, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output logic err, output logic rwe, output int lat,
                          output int t_acc);
        int n;
        logic c_we, c_oe;
        logic [DW-1:0] c_data, c_rd;
        lat = 999; t_acc = 0; rdata = '0; err = 1'b0; rwe = 1'b0;
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        end
        n = 0;
        while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) begin
            a_req_valid = 1'b0; b_req_valid = 1'b0;
            return;
        end
        t_acc = cyc;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        n = 1;
        forever begin
            c_we   = sel ? b_ram_we   : a_ram_we;
            c_oe   = sel ? b_ram_oe   : a_ram_oe;
            c_data = sel ? b_ram_data : a_ram_data;
            c_rd   = sel ? b_rd_q     : a_rd_q;
            checks++;
            if (c_we && c_oe) begin
                errors++;
                $display("FAIL bus_we_oe: we=%0b oe=%0b, required not both 1", c_we, c_oe);
            end
            if (c_oe) begin
                checks++;
                if (c_data !== c_rd) begin
                    errors++;
                    $display("FAIL bus_rd_data: bus=%h, required RAM value %h", c_data, c_rd);
                end
            end
            if (sel ? b_rsp_valid : a_rsp_valid) break;
            if (n >= 50) return;
            @(negedge clk); n++;
        end
        lat   = n;
        rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        err   = sel ? b_rsp_err   : a_rsp_err;
        rwe   = sel ? b_rsp_we    : a_rsp_we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", a_req_ready); end
        checks++;
        if ({a_rsp_valid, a_rsp_we, a_rsp_err} !== 3'b000) begin
            errors++; $display("FAIL rst_rsp_flags: got %b want 000", {a_rsp_valid, a_rsp_we, a_rsp_err});
        end
        checks++;
        if ({a_ram_cs, a_ram_we, a_ram_oe} !== 3'b000) begin
            errors++; $display("FAIL rst_ram_strobes: got %b want 000", {a_ram_cs, a_ram_we, a_ram_oe});
        end
        checks++;
        if (a_rsp_rdata !== 8'h00 || a_ram_addr !== 4'h0) begin
            errors++; $display("FAIL rst_regs: rdata=%h addr=%h want 00/0", a_rsp_rdata, a_ram_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: got %b%b want 11", a_req_ready, b_req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; logic err, rwe; int lat, t;
        a_rsp_ready = 1'b1;
        do_req(0, 1'b1, 4'd3, 8'hA5, rd, err, rwe, lat, t);
        model_a[3] = 8'hA5;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++;
        if ({rwe, err, rd} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL wr_rsp: we=%b err=%b rdata=%h want 1/0/00", rwe, err, rd);
        end
        @(negedge clk);
        checks++;
        if (a_mem[3] !== 8'hA5) begin errors++; $display("FAIL wr_ram_content: got %h want a5", a_mem[3]); end
        do_req(0, 1'b0, 4'd3, 8'h00, rd, err, rwe, lat, t);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
        checks++;
        if ({rwe, err, rd} !== {1'b0, 1'b0, model_a[3]}) begin
            errors++; $display("FAIL rd_rsp: we=%b err=%b rdata=%h want 0/0/%h", rwe, err, rd, model_a[3]);
        end
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_hold: valid=%b rdata=%h want 0/a5", a_rsp_valid, a_rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'd3;
        while (!a_req_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ram_cs, a_ram_oe} !== 2'b11) begin
            errors++; $display("FAIL mid_rd_data_state: cs/oe=%b want 11", {a_ram_cs, a_ram_oe});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ram_cs, a_ram_oe, a_rsp_valid, a_req_ready} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_outputs: cs,oe,rsp_valid,req_ready=%b want 0000",
                               {a_ram_cs, a_ram_oe, a_rsp_valid, a_req_ready});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_rsp: got %0d responses want 0", seen); end
        checks++;
        if (a_req_ready !== 1'b1 || a_rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL mid_reset_after: ready=%b rdata=%h want 1/00", a_req_ready, a_rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd; logic err, rwe; int lat, t, t_prev, bad_lat, bad_gap, bad_data;
        a_rsp_ready = 1'b1;
        bad_lat = 0; bad_gap = 0; bad_data = 0; t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 8'(i) ^ 8'hFF;
            do_req(0, 1'b1, 4'(i), 8'(i) ^ 8'hFF, rd, err, rwe, lat, t);
            if (lat != 2) bad_lat++;
            if (i > 0 && t - t_prev != 3) bad_gap++;
            t_prev = t;
        end
        for (int i = 0; i < 16; i++) begin
            do_req(0, 1'b0, 4'(i), 8'h00, rd, err, rwe, lat, t);
            if (lat != 3) bad_lat++;
            if (t - t_prev != (i == 0 ? 3 : 4)) bad_gap++;
            if (rd !== model_a[i] || err !== 1'b0) bad_data++;
            t_prev = t;
        end
        @(negedge clk);
        checks++;
        if (bad_lat !== 0) begin errors++; $display("FAIL b2b_latency: %0d wrong, want 0", bad_lat); end
        checks++;
        if (bad_gap !== 0) begin errors++; $display("FAIL b2b_throughput: %0d wrong gaps, want 0", bad_gap); end
        checks++;
        if (bad_data !== 0) begin errors++; $display("FAIL b2b_read_data: %0d wrong words, want 0", bad_data); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] rd; logic err, rwe; int lat, t;
        logic [AW-1:0] addr;
        addr = 4'($urandom_range(0, 15));
        a_rsp_ready = 1'b0;
        do_req(0, 1'b0, addr, 8'h00, rd, err, rwe, lat, t);
        checks++;
        if (lat !== 3 || rd !== model_a[addr]) begin
            errors++; $display("FAIL bp_first: lat=%0d rdata=%h want 3/%h", lat, rd, model_a[addr]);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({a_rsp_valid, a_rsp_we, a_rsp_err, a_req_ready, a_ram_cs} !== 5'b10000 ||
                a_rsp_rdata !== model_a[addr]) begin
                errors++;
                $display("FAIL bp_hold: valid,we,err,ready,cs=%b rdata=%h want 10000/%h",
                         {a_rsp_valid, a_rsp_we, a_rsp_err, a_req_ready, a_ram_cs}, a_rsp_rdata, model_a[addr]);
            end
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready);
        end
    endtask

    task automatic test_error();
        logic [DW-1:0] rd, d; logic err, rwe; int lat, t, cs0, bad;
        b_rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(1, 255));
            model_b[i] = d;
            do_req(1, 1'b1, 4'(i), d, rd, err, rwe, lat, t);
            if (lat != 2 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL err_prefill: %0d bad writes want 0", bad); end
        do_req(1, 1'b0, 4'd11, 8'h00, rd, err, rwe, lat, t);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== model_b[11]) begin
            errors++; $display("FAIL err_last_legal: lat=%0d err=%b rdata=%h want 3/0/%h", lat, err, rd, model_b[11]);
        end
        @(negedge clk);
        cs0 = b_cs_cnt;
        do_req(1, 1'b1, 4'd12, 8'h3C, rd, err, rwe, lat, t);
        checks++;
        if (lat !== 1 || {rwe, err, rd} !== {1'b1, 1'b1, 8'h00}) begin
            errors++; $display("FAIL err_write: lat=%0d we=%b err=%b rdata=%h want 1/1/1/00", lat, rwe, err, rd);
        end
        do_req(1, 1'b0, 4'd12, 8'h00, rd, err, rwe, lat, t);
        checks++;
        if (lat !== 1 || {rwe, err, rd} !== {1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL err_read: lat=%0d we=%b err=%b rdata=%h want 1/0/1/00", lat, rwe, err, rd);
        end
        do_req(1, 1'b0, 4'd15, 8'h00, rd, err, rwe, lat, t);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (b_cs_cnt !== cs0) begin
            errors++; $display("FAIL err_no_ram_access: cs cycles=%0d want 0", b_cs_cnt - cs0);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, d, exp_rd; logic err, rwe, we, sel, exp_err; int lat, exp_lat, t, stall;
        logic [AW-1:0] addr;
        for (int k = 0; k < 60; k++) begin
            sel   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = 4'($urandom_range(0, 15));
            d     = 8'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            a_rsp_ready = (stall == 0); b_rsp_ready = (stall == 0);
            exp_err = sel && (addr >= 4'd12);
            exp_lat = exp_err ? 1 : (we ? 2 : 3);
            exp_rd  = (exp_err || we) ? 8'h00 : (sel ? model_b[addr] : model_a[addr]);
            if (!exp_err && we) begin
                if (sel) model_b[addr] = d; else model_a[addr] = d;
            end
            do_req(sel, we, addr, d, rd, err, rwe, lat, t);
            checks++;
            if (lat !== exp_lat || err !== exp_err || rwe !== we || rd !== exp_rd) begin
                errors++;
                $display("FAIL rnd_%0d: sel=%0b we=%b addr=%0d lat=%0d err=%b rwe=%b rdata=%h want %0d/%b/%b/%h",
                         k, sel, we, addr, lat, err, rwe, rd, exp_lat, exp_err, we, exp_rd);
            end
            repeat (stall) @(negedge clk);
            if (stall != 0) begin
                checks++;
                if ((sel ? b_rsp_valid : a_rsp_valid) !== 1'b1 || (sel ? b_rsp_rdata : a_rsp_rdata) !== exp_rd) begin
                    errors++; $display("FAIL rnd_stall_%0d: response not held, want rdata %h", k, exp_rd);
                end
            end
            a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid_read();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
